// File: rtl/mips_pkg.sv
// Shared MIPS definitions: HI/LO multiply/divide op encodings used by the
// control decoder and by muldiv_unit.
package mips_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers: one shift-add or
// restoring shift-subtract step per cycle, 32 steps per operation.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for start; MTHI/MTLO writes land here
//   RUN    | one datapath step per cycle; HI/LO written on the last step
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_RUN     = 1'b1;
  localparam logic [4:0] LAST_STEP = 5'(WIDTH - 1);

  logic [0:0]         r_state;
  logic [4:0]         r_cnt;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_is_div;
  logic               r_neg_lo;
  logic               r_neg_hi;

  logic               w_signed;
  logic               w_rs_neg;
  logic               w_rt_neg;
  logic [WIDTH-1:0]   w_rs_mag;
  logic [WIDTH-1:0]   w_rt_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_signed = op_is_signed(op);
  assign w_rs_neg = w_signed & rs_data[WIDTH-1];
  assign w_rt_neg = w_signed & rt_data[WIDTH-1];
  assign w_rs_mag = w_rs_neg ? -rs_data : rs_data;
  assign w_rt_mag = w_rt_neg ? -rt_data : rt_data;

  // Multiply: {upper, multiplier} shifts right, multiplicand added into upper.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: shift left, trial-subtract divisor; the sign bit of the
  // (WIDTH+1)-bit difference says whether the subtraction is kept.
  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_rem_sh - {1'b0, r_opnd};
  assign w_div_next = w_diff[WIDTH]
                    ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                    : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};

  assign w_acc_next = r_is_div ? w_div_next : w_mul_next;

  assign w_prod   = r_neg_lo ? -w_acc_next : w_acc_next;
  assign w_quo    = r_neg_lo ? -w_acc_next[WIDTH-1:0] : w_acc_next[WIDTH-1:0];
  assign w_rem    = r_neg_hi ? -w_acc_next[2*WIDTH-1:WIDTH] : w_acc_next[2*WIDTH-1:WIDTH];
  assign w_res_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
  assign w_res_lo = r_is_div ? w_quo : w_prod[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_RUN;
            r_cnt    <= '0;
            r_acc    <= {{WIDTH{1'b0}}, w_rs_mag};
            r_opnd   <= w_rt_mag;
            r_is_div <= op_is_div(op);
            // A zero divisor leaves an all-ones quotient and the dividend
            // magnitude as remainder; skipping the quotient negation and
            // re-applying the dividend sign returns rs unchanged in HI.
            r_neg_lo <= (w_rs_neg ^ w_rt_neg) & (|rt_data);
            r_neg_hi <= w_rs_neg;
          end else begin
            if (hi_we) r_hi <= mt_data;
            if (lo_we) r_lo <= mt_data;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == LAST_STEP) begin
            r_hi    <= w_res_hi;
            r_lo    <= w_res_lo;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model compared every
// cycle, directed corner cases pinned by literals, then randomized traffic.
module tb_muldiv_unit;
  import mips_pkg::*;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic        start   = 1'b0;
  logic [1:0]  op      = 2'b00;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        hi_we   = 1'b0;
  logic        lo_we   = 1'b0;
  logic [31:0] mt_data = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .hi_we(hi_we), .lo_we(lo_we), .mt_data(mt_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model: HI/LO contents, cycles left in the running operation,
  // and the pending result computed with plain 64-bit arithmetic.
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_left = 0;
  logic        m_done = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] rh, output logic [31:0] rl);
    longint      sa, sb, sp, sq, sr;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    rh = '0;
    rl = '0;
    case (o)
      OP_MULT: begin
        sp = sa * sb;
        rh = sp[63:32];
        rl = sp[31:0];
      end
      OP_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        rh = up[63:32];
        rl = up[31:0];
      end
      OP_DIV: begin
        if (b == 0) begin
          rh = a;
          rl = 32'hFFFF_FFFF;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          rh = sr[31:0];
          rl = sq[31:0];
        end
      end
      default: begin
        if (b == 0) begin
          rh = a;
          rl = 32'hFFFF_FFFF;
        end else begin
          rh = a % b;
          rl = a / b;
        end
      end
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_left = 0;
      m_hi   = '0;
      m_lo   = '0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi   = p_hi;
          m_lo   = p_lo;
          m_done = 1'b1;
        end
      end else if (start) begin
        ref_op(op, rs_data, rt_data, p_hi, p_lo);
        m_left = 32;
      end else begin
        if (hi_we) m_hi = mt_data;
        if (lo_we) m_lo = mt_data;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("done", 32'(done), 32'(m_done));
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op      = o;
    rs_data = a;
    rt_data = b;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    op      = 2'($urandom);
    rs_data = $urandom;
    rt_data = $urandom;
  endtask

  task automatic wait_done(input string nm, output int bc);
    int n;
    n  = 0;
    bc = 0;
    while (done !== 1'b1 && n < 64) begin
      if (busy === 1'b1) bc++;
      tick();
      n++;
    end
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL %s_timeout: done got 0 expected 1 within 64 cycles", nm);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int bc;

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", bc);
    chk("multu_max_busy_cycles", 32'(bc), 32'd32);
    chk("multu_max_hi", hi, 32'hFFFF_FFFE);
    chk("multu_max_lo", lo, 32'h0000_0001);
    tick();
    chk("multu_max_done_1cyc", 32'(done), 32'd0);

    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done("mult_neg", bc);
    chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo", lo, 32'hFFFF_FFEB);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", bc);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);

    issue(OP_DIVU, 32'd100, 32'd0);
    wait_done("divu_zero", bc);
    chk("divu_zero_busy_cycles", 32'(bc), 32'd32);
    chk("divu_zero_lo", lo, 32'hFFFF_FFFF);
    chk("divu_zero_hi", hi, 32'd100);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd0);
    wait_done("div_zero_neg", bc);
    chk("div_zero_neg_lo", lo, 32'hFFFF_FFFF);
    chk("div_zero_neg_hi", hi, 32'hFFFF_FFF9);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", bc);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'd0);

    // Start and MT strobes during RUN must be ignored.
    issue(OP_DIVU, 32'd1000, 32'd7);
    repeat (5) tick();
    start = 1'b1; op = OP_MULT; rs_data = 32'd5; rt_data = 32'd5;
    hi_we = 1'b1; lo_we = 1'b1; mt_data = 32'hDEAD_BEEF;
    tick();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    wait_done("busy_ignore", bc);
    chk("busy_ignore_lo", lo, 32'd142);
    chk("busy_ignore_hi", hi, 32'd6);
    tick();

    hi_we = 1'b1; mt_data = 32'hA5A5_A5A5;
    tick();
    hi_we = 1'b0;
    chk("mthi_hi", hi, 32'hA5A5_A5A5);
    chk("mthi_lo", lo, 32'd142);
    hi_we = 1'b1; lo_we = 1'b1; mt_data = 32'h1234_5678;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mtboth_hi", hi, 32'h1234_5678);
    chk("mtboth_lo", lo, 32'h1234_5678);

    // MT write in the same cycle as an accepted start is dropped.
    hi_we = 1'b1; mt_data = 32'hFFFF_0000;
    issue(OP_MULTU, 32'd2, 32'd3);
    hi_we = 1'b0;
    wait_done("start_mt", bc);
    chk("start_mt_hi", hi, 32'd0);
    chk("start_mt_lo", lo, 32'd6);

    // Reset in the middle of RUN aborts without a done pulse.
    hi_we = 1'b1; lo_we = 1'b1; mt_data = 32'h0000_BEEF;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    issue(OP_MULTU, 32'd6, 32'd7);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    bc = 0;
    repeat (30) begin
      if (done === 1'b1) bc++;
      tick();
    end
    chk("abort_no_done", 32'(bc), 32'd0);

    // Back-to-back: next start issued in the done cycle.
    issue(OP_MULTU, 32'd6, 32'd7);
    wait_done("b2b_first", bc);
    chk("b2b_first_busy_cycles", 32'(bc), 32'd32);
    chk("b2b_first_lo", lo, 32'd42);
    issue(OP_DIVU, 32'd42, 32'd5);
    wait_done("b2b_second", bc);
    chk("b2b_second_busy_cycles", 32'(bc), 32'd32);
    chk("b2b_second_lo", lo, 32'd8);
    chk("b2b_second_hi", hi, 32'd2);

    for (int c = 0; c < 6000; c++) begin
      start   = ($urandom_range(0, 3) == 0);
      op      = 2'($urandom);
      rs_data = pick();
      rt_data = pick();
      hi_we   = ($urandom_range(0, 7) == 0);
      lo_we   = ($urandom_range(0, 7) == 0);
      mt_data = $urandom;
      reset   = ($urandom_range(0, 999) == 0);
      tick();
    end

    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; reset = 1'b0;
    repeat (40) tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width; only 32 is required to work.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  request a new operation; sampled on rising edge of clk.
REQ-005 op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 rs_data  in  32  first operand (register file read_data1).
REQ-007 rt_data  in  32  second operand (register file read_data2).
REQ-008 hi_we  in  1  MTHI write strobe.
REQ-009 lo_we  in  1  MTLO write strobe.
REQ-010 mt_data  in  32  data for MTHI/MTLO.
REQ-011 busy  out  1  operation in progress.
REQ-012 done  out  1  one-cycle pulse: HI/LO just updated by an operation.
REQ-013 hi  out  32  HI register (MFHI source).
REQ-014 lo  out  32  LO register (MFLO source).

Function
REQ-015 States: IDLE, RUN; 5-bit iteration counter.
REQ-016 IDLE: start=1 -> latch op, rs_data, rt_data; go to RUN; counter=0; busy=1 from next cycle.
REQ-017 RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; exactly 32 cycles with busy=1.
REQ-018 On the edge ending the 32nd RUN cycle: HI/LO take the result, state returns to IDLE, busy=0, done=1 for exactly one cycle.
REQ-019 Latency: start sampled at edge N -> results visible on hi/lo and done=1 after edge N+32.
REQ-020 MULT/MULTU: {HI,LO} = 64-bit product; MULT signed two's complement, MULTU unsigned.
REQ-021 DIV/DIVU: LO = quotient, HI = remainder; signed quotient truncates toward zero, remainder takes sign of dividend (rs).
REQ-022 Signed operations: compute on magnitudes, then negate product/quotient/remainder per sign rules.
REQ-023 Divide by zero (rt_data=0, DIV or DIVU): LO=32'hFFFF_FFFF, HI=latched rs_data; still 32 cycles, done pulses.
REQ-024 DIV 0x8000_0000 / 0xFFFF_FFFF: LO=32'h8000_0000, HI=0.
REQ-025 start while busy=1: ignored; running operation unaffected.
REQ-026 hi_we/lo_we in IDLE with start=0: HI/LO loaded from mt_data at that edge; both strobes high writes both.
REQ-027 hi_we/lo_we while busy=1, or in same cycle as an accepted start: dropped; no effect.
REQ-028 start in the same cycle as done=1: accepted (state already IDLE), back-to-back issue allowed.
REQ-029 Operand inputs may change after start is accepted without affecting the result.
REQ-030 hi/lo hold value whenever not written per REQ-018/REQ-026; never show partial results.

Reset
REQ-031 reset=1 at a rising edge: state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0.
REQ-032 Reset during RUN aborts the operation; no done pulse, no partial result on HI/LO.
REQ-033 reset overrides start, hi_we and lo_we in the same cycle.

Structure
REQ-034 op encodings (MULT, MULTU, DIV, DIVU) shall be localparams in shared package mips_pkg, used also by the control decoder.
REQ-035 State encoding shall be local to the module.
REQ-036 Single module; no sub-module; datapath is 64-bit accumulator/remainder-quotient shift register plus latched divisor/multiplicand.

Verification
REQ-037 MULTU 0xFFFF_FFFF x 0xFFFF_FFFF -> after 32 busy cycles HI=0xFFFF_FFFE, LO=0x0000_0001, done one cycle.
REQ-038 MULT -3 x 7 -> HI=0xFFFF_FFFF, LO=0xFFFF_FFEB; DIV -7/2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
REQ-039 DIVU 100/0 -> LO=0xFFFF_FFFF, HI=100; DIV 0x8000_0000/-1 -> LO=0x8000_0000, HI=0.
REQ-040 start and hi_we pulsed mid-RUN, operands changed -> result equals original operation, HI unchanged by mt_data.
REQ-041 reset asserted at RUN cycle 10 -> busy=0, hi=lo=0 next cycle, no done pulse; new start then completes normally.
REQ-042 start in done cycle (MULTU 6x7 then DIVU 42/5) -> LO=42 then LO=8, HI=2, each 32 busy cycles, no idle gap.
